// File: rtl/cpu_types.sv
// -----------------------------------------------------------------------------
// cpu_types
// Shared types for the pipelined OTTER control path.
//   pipe_state_t : sequencing states of the pipeline controller
//   pc_sel_t     : next-PC source select driven into the PC mux
// -----------------------------------------------------------------------------
package cpu_types;

    typedef enum logic [2:0] {
        HOLD      = 3'd0,
        FILL      = 3'd1,
        RUN       = 3'd2,
        INT_DRAIN = 3'd3,
        INT_ENTER = 3'd4
    } pipe_state_t;

    typedef enum logic [1:0] {
        PC4     = 2'd0,
        EXREDIR = 2'd1,
        MTVEC   = 2'd2,
        MEPC    = 2'd3
    } pc_sel_t;

    // Wide enough for the largest supported drain length (7)
    localparam int DRAIN_W = 3;

    // States in which lost pipeline slots are charged to the stall counter
    function automatic logic is_counted_state(pipe_state_t s);
        return (s == RUN) || (s == INT_DRAIN) || (s == INT_ENTER);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with asynchronous active-low clear.
//   clk   : clock, counts on rising edge
//   rst_n : asynchronous active-low clear
//   inc   : count enable for this cycle
//   count : current value, sticks at all-ones
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up when asked, but once every bit is set hold there for good
    // so a long stall storm never wraps back to a small value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Central stall/flush/next-PC sequencer for the five-stage OTTER pipeline.
// Outputs are decoded from the registered state plus the current cycle's
// hazard inputs, so they are valid in the same cycle as the event.
//   CLK, RESET_N          : clock, async active-low reset
//   PROG_RESET            : programmer reset, holds the pipeline empty
//   INTR, INT_EN          : interrupt request and global enable
//   LD_HAZ                : load-use hazard between EX and DE
//   JB_TAKEN, MRET        : control transfers resolved in EX
//   DE_PC                 : PC of the DE instruction (return address)
//   PC_WE, IF_ID_WE, DE_EX_WE            : register write enables
//   IF_ID_FLUSH, DE_EX_FLUSH, EX_MEM_FLUSH : bubble insertion
//   PC_SEL                : next-PC source (PC4/EXREDIR/MTVEC/MEPC)
//   INT_TAKEN             : one-cycle interrupt commit pulse to the CSRs
//   EPC                   : latched return PC
//   STALL_CNT             : saturating count of stalled/flushed cycles
// -----------------------------------------------------------------------------
module pipe_ctrl
    import cpu_types::*;
#(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             PROG_RESET,
    input  logic             INTR,
    input  logic             INT_EN,
    input  logic             LD_HAZ,
    input  logic             JB_TAKEN,
    input  logic             MRET,
    input  logic [31:0]      DE_PC,
    output logic             PC_WE,
    output logic             IF_ID_WE,
    output logic             DE_EX_WE,
    output logic             IF_ID_FLUSH,
    output logic             DE_EX_FLUSH,
    output logic             EX_MEM_FLUSH,
    output logic [1:0]       PC_SEL,
    output logic             INT_TAKEN,
    output logic [31:0]      EPC,
    output logic [CNT_W-1:0] STALL_CNT
);

    pipe_state_t        state;
    pipe_state_t        next_state;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [31:0]        epc_q;
    pc_sel_t            pc_sel;
    logic               irq;
    logic               start_drain;
    logic               count_stall;

    assign irq = INTR & INT_EN;

    // Output and next-state decode. Defaults are the empty-pipeline values,
    // which is exactly what HOLD (and a programmer reset in any state) needs.
    // In RUN the if/else chain encodes the event priority; a taken branch
    // beats a load hazard because the dependent instruction is squashed.
    always_comb begin
        next_state   = state;
        PC_WE        = 1'b0;
        IF_ID_WE     = 1'b0;
        DE_EX_WE     = 1'b0;
        IF_ID_FLUSH  = 1'b1;
        DE_EX_FLUSH  = 1'b1;
        EX_MEM_FLUSH = 1'b1;
        pc_sel       = PC4;
        INT_TAKEN    = 1'b0;
        start_drain  = 1'b0;

        if (PROG_RESET) begin
            next_state = HOLD;
        end else begin
            case (state)
                HOLD: begin
                    next_state = FILL;
                end
                FILL: begin
                    PC_WE      = 1'b1;
                    IF_ID_WE   = 1'b1;
                    DE_EX_WE   = 1'b1;
                    next_state = RUN;
                end
                RUN: begin
                    PC_WE        = 1'b1;
                    IF_ID_WE     = 1'b1;
                    DE_EX_WE     = 1'b1;
                    IF_ID_FLUSH  = 1'b0;
                    DE_EX_FLUSH  = 1'b0;
                    EX_MEM_FLUSH = 1'b0;
                    if (MRET) begin
                        pc_sel      = MEPC;
                        IF_ID_FLUSH = 1'b1;
                        DE_EX_FLUSH = 1'b1;
                    end else if (JB_TAKEN) begin
                        pc_sel      = EXREDIR;
                        IF_ID_FLUSH = 1'b1;
                        DE_EX_FLUSH = 1'b1;
                    end else if (irq) begin
                        PC_WE       = 1'b0;
                        IF_ID_FLUSH = 1'b1;
                        DE_EX_FLUSH = 1'b1;
                        start_drain = 1'b1;
                        next_state  = INT_DRAIN;
                    end else if (LD_HAZ) begin
                        PC_WE       = 1'b0;
                        IF_ID_WE    = 1'b0;
                        DE_EX_FLUSH = 1'b1;
                    end
                end
                INT_DRAIN: begin
                    // EX only holds bubbles now, so EX-stage events are moot
                    IF_ID_WE     = 1'b1;
                    DE_EX_WE     = 1'b1;
                    EX_MEM_FLUSH = 1'b0;
                    if (drain_cnt == DRAIN_W'(1)) begin
                        next_state = INT_ENTER;
                    end
                end
                INT_ENTER: begin
                    PC_WE        = 1'b1;
                    IF_ID_WE     = 1'b1;
                    DE_EX_WE     = 1'b1;
                    EX_MEM_FLUSH = 1'b0;
                    pc_sel       = MTVEC;
                    INT_TAKEN    = 1'b1;
                    next_state   = RUN;
                end
                default: begin
                    next_state = HOLD;
                end
            endcase
        end
    end

    // State, drain counter and return PC. The drain counter is loaded with
    // the drain length as the interrupt is accepted and the FSM moves on to
    // INT_ENTER when it reads 1, giving exactly DRAIN_CYCLES drain cycles.
    // A programmer reset also discards any latched return PC.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= HOLD;
            drain_cnt <= '0;
            epc_q     <= '0;
        end else begin
            state <= next_state;
            if (start_drain) begin
                drain_cnt <= DRAIN_W'(DRAIN_CYCLES);
            end else if (state == INT_DRAIN && drain_cnt != '0) begin
                drain_cnt <= drain_cnt - 1'b1;
            end
            if (PROG_RESET) begin
                epc_q <= '0;
            end else if (start_drain) begin
                epc_q <= DE_PC;
            end
        end
    end

    // A cycle is charged to the counter when it loses a slot: something is
    // flushed or the PC is frozen while the pipeline is live.
    assign count_stall = is_counted_state(state) &&
                         (IF_ID_FLUSH || DE_EX_FLUSH || EX_MEM_FLUSH || !PC_WE);

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (CLK),
        .rst_n (RESET_N),
        .inc   (count_stall),
        .count (STALL_CNT)
    );

    assign PC_SEL = pc_sel;
    assign EPC    = epc_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Directed plus randomized bench for pipe_ctrl. Two instances share the
// stimulus: one with the default counter width and one with a 4-bit counter
// for saturation. Expected values come from a cycle-indexed timeline model.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam int D     = 2;
    localparam int SAT_W = 4;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        PROG_RESET, INTR, INT_EN, LD_HAZ, JB_TAKEN, MRET;
    logic [31:0] DE_PC;

    logic        PC_WE, IF_ID_WE, DE_EX_WE, IF_ID_FLUSH, DE_EX_FLUSH, EX_MEM_FLUSH;
    logic [1:0]  PC_SEL;
    logic        INT_TAKEN;
    logic [31:0] EPC;
    logic [15:0] STALL_CNT;

    logic        s_pc_we, s_if_id_we, s_de_ex_we, s_if_fl, s_de_fl, s_ex_fl;
    logic [1:0]  s_pc_sel;
    logic        s_int_taken;
    logic [31:0] s_epc;
    logic [SAT_W-1:0] s_stall;

    // Model state: a timeline keyed on the cycle number
    int          cyc;
    int          lastProg;
    int          intSampled;
    logic [31:0] mEpc;
    int          mStall;

    // Expected combinational outputs for the current cycle
    logic        eWe, eIfWe, eDeWe, eIfFl, eDeFl, eExFl, eTaken;
    logic [1:0]  eSel;
    logic        eCount, eAccept;

    int passCount = 0;
    int checkCount = 0;
    int failCount = 0;

    always #5 CLK = ~CLK;

    pipe_ctrl #(.DRAIN_CYCLES(D), .CNT_W(16)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .PROG_RESET(PROG_RESET), .INTR(INTR),
        .INT_EN(INT_EN), .LD_HAZ(LD_HAZ), .JB_TAKEN(JB_TAKEN), .MRET(MRET),
        .DE_PC(DE_PC), .PC_WE(PC_WE), .IF_ID_WE(IF_ID_WE), .DE_EX_WE(DE_EX_WE),
        .IF_ID_FLUSH(IF_ID_FLUSH), .DE_EX_FLUSH(DE_EX_FLUSH),
        .EX_MEM_FLUSH(EX_MEM_FLUSH), .PC_SEL(PC_SEL), .INT_TAKEN(INT_TAKEN),
        .EPC(EPC), .STALL_CNT(STALL_CNT)
    );

    pipe_ctrl #(.DRAIN_CYCLES(D), .CNT_W(SAT_W)) dut_sat (
        .CLK(CLK), .RESET_N(RESET_N), .PROG_RESET(PROG_RESET), .INTR(INTR),
        .INT_EN(INT_EN), .LD_HAZ(LD_HAZ), .JB_TAKEN(JB_TAKEN), .MRET(MRET),
        .DE_PC(DE_PC), .PC_WE(s_pc_we), .IF_ID_WE(s_if_id_we), .DE_EX_WE(s_de_ex_we),
        .IF_ID_FLUSH(s_if_fl), .DE_EX_FLUSH(s_de_fl), .EX_MEM_FLUSH(s_ex_fl),
        .PC_SEL(s_pc_sel), .INT_TAKEN(s_int_taken), .EPC(s_epc), .STALL_CNT(s_stall)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    // Works out what this cycle should look like from where we are on the
    // timeline: just after a hold trigger, the fill slot after it, inside an
    // interrupt drain window, the entry slot, or normal running.
    task automatic computeExpected();
        int  phase;   // 0 hold, 1 fill, 2 drain, 3 enter, 4 run
        logic live;
        if (!RESET_N || cyc == lastProg + 1) phase = 0;
        else if (cyc == lastProg + 2) phase = 1;
        else if (intSampled >= 0 && cyc > intSampled && cyc <= intSampled + D) phase = 2;
        else if (intSampled >= 0 && cyc == intSampled + D + 1) phase = 3;
        else phase = 4;
        live = RESET_N && (phase >= 2);

        {eWe, eIfWe, eDeWe} = 3'b000;
        {eIfFl, eDeFl, eExFl} = 3'b111;
        eSel = 2'd0; eTaken = 1'b0; eAccept = 1'b0;
        case (phase)
            1: {eWe, eIfWe, eDeWe} = 3'b111;
            2: begin {eWe, eIfWe, eDeWe} = 3'b011; eExFl = 1'b0; end
            3: begin {eWe, eIfWe, eDeWe} = 3'b111; eExFl = 1'b0; eSel = 2'd2; eTaken = 1'b1; end
            4: begin
                {eWe, eIfWe, eDeWe} = 3'b111;
                {eIfFl, eDeFl, eExFl} = 3'b000;
                if (MRET) begin eSel = 2'd3; eIfFl = 1'b1; eDeFl = 1'b1; end
                else if (JB_TAKEN) begin eSel = 2'd1; eIfFl = 1'b1; eDeFl = 1'b1; end
                else if (INTR && INT_EN) begin eWe = 1'b0; eIfFl = 1'b1; eDeFl = 1'b1; eAccept = 1'b1; end
                else if (LD_HAZ) begin eWe = 1'b0; eIfWe = 1'b0; eDeFl = 1'b1; end
            end
            default: ;
        endcase
        if (PROG_RESET && RESET_N) begin
            {eWe, eIfWe, eDeWe} = 3'b000;
            {eIfFl, eDeFl, eExFl} = 3'b111;
            eSel = 2'd0; eTaken = 1'b0; eAccept = 1'b0;
        end
        eCount = live && (eIfFl || eDeFl || eExFl || !eWe);
    endtask

    task automatic applyStimulus(input bit pr, input bit irq, input bit en, input bit ld,
                                 input bit jb, input bit mr, input logic [31:0] pc);
        PROG_RESET = pr; INTR = irq; INT_EN = en; LD_HAZ = ld;
        JB_TAKEN = jb; MRET = mr; DE_PC = pc;
        computeExpected();
    endtask

    task automatic checkComb(input string tag);
        checkOutput({tag, ".PC_WE"}, 32'(PC_WE), 32'(eWe));
        checkOutput({tag, ".IF_ID_WE"}, 32'(IF_ID_WE), 32'(eIfWe));
        checkOutput({tag, ".DE_EX_WE"}, 32'(DE_EX_WE), 32'(eDeWe));
        checkOutput({tag, ".IF_ID_FLUSH"}, 32'(IF_ID_FLUSH), 32'(eIfFl));
        checkOutput({tag, ".DE_EX_FLUSH"}, 32'(DE_EX_FLUSH), 32'(eDeFl));
        checkOutput({tag, ".EX_MEM_FLUSH"}, 32'(EX_MEM_FLUSH), 32'(eExFl));
        checkOutput({tag, ".PC_SEL"}, 32'(PC_SEL), 32'(eSel));
        checkOutput({tag, ".INT_TAKEN"}, 32'(INT_TAKEN), 32'(eTaken));
        checkOutput({tag, ".sat.PC_SEL"}, 32'(s_pc_sel), 32'(eSel));
        checkOutput({tag, ".sat.INT_TAKEN"}, 32'(s_int_taken), 32'(eTaken));
    endtask

    task automatic checkRegs(input string tag);
        int satMax;
        satMax = (1 << SAT_W) - 1;
        checkOutput({tag, ".EPC"}, EPC, mEpc);
        checkOutput({tag, ".STALL_CNT"}, 32'(STALL_CNT), 32'(mStall > 65535 ? 65535 : mStall));
        checkOutput({tag, ".sat.STALL_CNT"}, 32'(s_stall), 32'(mStall > satMax ? satMax : mStall));
    endtask

    // One clock cycle: drive, check decode mid-cycle, advance the timeline
    // on the edge, then check the registered outputs just after it.
    task automatic step(input string tag, input bit pr, input bit irq, input bit en,
                        input bit ld, input bit jb, input bit mr, input logic [31:0] pc);
        applyStimulus(pr, irq, en, ld, jb, mr, pc);
        @(negedge CLK);
        checkComb(tag);
        @(posedge CLK);
        if (pr) begin
            lastProg = cyc; intSampled = -1; mEpc = 32'h0;
        end else if (eAccept) begin
            intSampled = cyc; mEpc = pc;
        end
        if (eCount) mStall++;
        cyc++;
        #1;
        checkRegs(tag);
    endtask

    task automatic resetModel();
        lastProg = cyc; intSampled = -1; mEpc = 32'h0; mStall = 0;
    endtask

    task automatic resetCycle(input string tag);
        RESET_N = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
        resetModel();
        #1;
        checkRegs(tag);
        @(negedge CLK);
        checkComb(tag);
        @(posedge CLK);
        cyc++;
        #1;
        RESET_N = 1'b1;
    endtask

    initial begin
        cyc = 0;
        resetModel();
        RESET_N = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
        @(posedge CLK);
        #1;

        // Reset and programmer reset bring-up
        resetCycle("reset");
        step("prog1", 1, 0, 0, 0, 0, 0, 32'h0);
        step("prog2", 1, 0, 0, 0, 0, 0, 32'h0);
        step("hold", 0, 0, 0, 0, 0, 0, 32'h0);
        step("fill", 0, 0, 0, 0, 0, 0, 32'h0);
        step("run", 0, 0, 0, 0, 0, 0, 32'h0);
        step("run2", 0, 0, 0, 0, 0, 0, 32'h4);

        // Single load-use stall, then branch over a hazard
        step("ldhaz", 0, 0, 0, 1, 0, 0, 32'h8);
        checkOutput("ldhaz.cnt_one", 32'(STALL_CNT), 32'd1);
        step("jb_ld", 0, 0, 0, 1, 1, 0, 32'hC);
        step("run3", 0, 0, 1, 0, 0, 0, 32'h10);

        // Interrupt with DE_PC = 0x40, request dropped mid-drain
        step("irq", 0, 1, 1, 0, 0, 0, 32'h40);
        checkOutput("irq.epc", EPC, 32'h40);
        step("drain1", 0, 0, 1, 1, 1, 1, 32'h44);
        step("drain2", 0, 0, 1, 0, 0, 0, 32'h48);
        step("enter", 0, 0, 1, 0, 0, 0, 32'h4C);
        step("post", 0, 0, 1, 0, 0, 0, 32'h50);

        // mret, then a long hazard run to saturate the narrow counter
        step("mret", 0, 0, 0, 0, 0, 1, 32'h54);
        for (int i = 0; i < 20; i++) step("ldrun", 0, 0, 0, 1, 0, 0, 32'h58);
        checkOutput("sat.hold15", 32'(s_stall), 32'd15);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step("rand", 0,
                 $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 70,
                 $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 8, $urandom() & 32'hFFFF_FFFC);
        end

        // Reset in the middle of a drain: EPC cleared, no entry pulse
        step("irq2", 0, 1, 1, 0, 0, 0, 32'h80);
        step("drain_a", 0, 0, 0, 0, 0, 0, 32'h84);
        resetCycle("mid_reset");
        step("hold2", 0, 1, 1, 0, 0, 0, 32'h0);
        step("fill2", 0, 1, 1, 0, 0, 0, 32'h0);
        step("run4", 0, 0, 0, 0, 0, 0, 32'h0);
        step("run5", 0, 0, 0, 0, 0, 0, 32'h0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
